dma_datapath_primitives: RTL and testbench



---
 rtl/dma_datapath_primitives.sv | 107 ++++++++++
 tb/tb_dma_datapath_primitives.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_datapath_primitives.sv
// DMA datapath storage primitives: a retry-capable FIFO, a loadable up-counter
// and a general enable register. They share only the clock and reset.
module dma_datapath_primitives #(
  parameter int unsigned DATA_LEN        = 16,
  parameter int unsigned FIFO_DEPTH      = 5,
  parameter int unsigned FIFO_DIV_FACTOR = 3,
  parameter int unsigned CNT_LEN         = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_rst,
  input  logic                fifo_enable,
  input  logic                fifo_wr_rd,
  input  logic                fifo_old_add_flag,
  input  logic [DATA_LEN-1:0] fifo_in,
  output logic [DATA_LEN-1:0] fifo_out,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                fifo_empty_partial,
  input  logic                cnt_rst,
  input  logic                cnt_en,
  input  logic                cnt_load,
  input  logic [CNT_LEN-1:0]  cnt_data_in,
  output logic [CNT_LEN-1:0]  cnt,
  output logic                cnt_end,
  input  logic                reg_rst,
  input  logic                reg_en,
  input  logic [DATA_LEN-1:0] reg_data_in,
  output logic [DATA_LEN-1:0] reg_data_out
);

  localparam int unsigned Entries   = 1 << FIFO_DEPTH;
  localparam int unsigned PtrW      = FIFO_DEPTH + 1;
  localparam int unsigned Threshold = Entries >> FIFO_DIV_FACTOR;

  logic [DATA_LEN-1:0] mem [Entries];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q, prev_wr_q, prev_rd_q;
  logic [PtrW-1:0]     occupancy;
  logic                do_write, do_read;
  logic [CNT_LEN-1:0]  cnt_q;
  logic [DATA_LEN-1:0] reg_q;

  // Extra wrap bit lets full and empty be told apart with equal low bits.
  assign occupancy          = wr_ptr_q - rd_ptr_q;
  assign fifo_full          = (occupancy == PtrW'(Entries));
  assign fifo_empty         = (occupancy == '0);
  assign fifo_empty_partial = (occupancy <= PtrW'(Threshold));
  assign fifo_out           = fifo_empty ? '0 : mem[rd_ptr_q[FIFO_DEPTH-1:0]];

  assign do_write = fifo_enable & fifo_wr_rd & ~fifo_full & ~fifo_rst & ~fifo_old_add_flag;
  assign do_read  = fifo_enable & ~fifo_wr_rd & ~fifo_empty & ~fifo_rst & ~fifo_old_add_flag;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q[FIFO_DEPTH-1:0]] <= fifo_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      prev_wr_q <= '0;
      prev_rd_q <= '0;
    end else if (fifo_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      prev_wr_q <= '0;
      prev_rd_q <= '0;
    end else if (fifo_old_add_flag) begin
      // Retry: roll back the last step on the side selected by fifo_wr_rd.
      if (fifo_wr_rd) wr_ptr_q <= prev_wr_q;
      else            rd_ptr_q <= prev_rd_q;
    end else if (do_write) begin
      prev_wr_q <= wr_ptr_q;
      wr_ptr_q  <= wr_ptr_q + PtrW'(1);
    end else if (do_read) begin
      prev_rd_q <= rd_ptr_q;
      rd_ptr_q  <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_rst) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      if (cnt_load) cnt_q <= cnt_data_in;
      else          cnt_q <= cnt_q + CNT_LEN'(1);
    end
  end

  assign cnt     = cnt_q;
  assign cnt_end = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
    end else if (reg_rst) begin
      reg_q <= '0;
    end else if (reg_en) begin
      reg_q <= reg_data_in;
    end
  end

  assign reg_data_out = reg_q;

endmodule

// File: tb/tb_dma_datapath_primitives.sv
// Directed bench for dma_datapath_primitives: FIFO fill/drain, thresholds,
// retry pointer restore, counter load/wrap, register and async reset.
module tb_dma_datapath_primitives;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_rst, fifo_enable, fifo_wr_rd, fifo_old_add_flag;
  logic [15:0] fifo_in, fifo_out;
  logic        fifo_full, fifo_empty, fifo_empty_partial;
  logic        cnt_rst, cnt_en, cnt_load;
  logic [14:0] cnt_data_in, cnt;
  logic        cnt_end;
  logic        reg_rst, reg_en;
  logic [15:0] reg_data_in, reg_data_out;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  dma_datapath_primitives dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fifo_rst           (fifo_rst),
    .fifo_enable        (fifo_enable),
    .fifo_wr_rd         (fifo_wr_rd),
    .fifo_old_add_flag  (fifo_old_add_flag),
    .fifo_in            (fifo_in),
    .fifo_out           (fifo_out),
    .fifo_full          (fifo_full),
    .fifo_empty         (fifo_empty),
    .fifo_empty_partial (fifo_empty_partial),
    .cnt_rst            (cnt_rst),
    .cnt_en             (cnt_en),
    .cnt_load           (cnt_load),
    .cnt_data_in        (cnt_data_in),
    .cnt                (cnt),
    .cnt_end            (cnt_end),
    .reg_rst            (reg_rst),
    .reg_en             (reg_en),
    .reg_data_in        (reg_data_in),
    .reg_data_out       (reg_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [15:0] d);
    fifo_enable = 1'b1;
    fifo_wr_rd  = 1'b1;
    fifo_in     = d;
    tick();
    fifo_enable = 1'b0;
  endtask

  task automatic fifo_pop();
    fifo_enable = 1'b1;
    fifo_wr_rd  = 1'b0;
    tick();
    fifo_enable = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " empty"},   32'(fifo_empty), 32'd1);
    chk({tag, " full"},    32'(fifo_full), 32'd0);
    chk({tag, " partial"}, 32'(fifo_empty_partial), 32'd1);
    chk({tag, " out"},     32'(fifo_out), 32'd0);
    chk({tag, " cnt"},     32'(cnt), 32'd0);
    chk({tag, " cnt_end"}, 32'(cnt_end), 32'd0);
    chk({tag, " reg"},     32'(reg_data_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_rst = 1'b0; fifo_enable = 1'b0; fifo_wr_rd = 1'b0; fifo_old_add_flag = 1'b0;
    fifo_in = '0;
    cnt_rst = 1'b0; cnt_en = 1'b0; cnt_load = 1'b0; cnt_data_in = '0;
    reg_rst = 1'b0; reg_en = 1'b0; reg_data_in = '0;
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // 1: fill to full, overflow ignored, drain in order
    for (int i = 0; i < 31; i++) fifo_write(16'(i));
    chk("full_at_31", 32'(fifo_full), 32'd0);
    fifo_write(16'd31);
    chk("full_at_32", 32'(fifo_full), 32'd1);
    fifo_write(16'hDEAD);
    chk("full_after_33", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain_%0d", i), 32'(fifo_out), 32'(i));
      fifo_pop();
    end
    chk("drained_empty", 32'(fifo_empty), 32'd1);
    chk("drained_out", 32'(fifo_out), 32'd0);
    fifo_pop();
    chk("pop_empty_ignored", 32'(fifo_empty), 32'd1);

    // 2: partial-empty threshold at occupancy 4
    for (int i = 0; i < 6; i++) fifo_write(16'(100 + i));
    chk("partial_occ6", 32'(fifo_empty_partial), 32'd0);
    fifo_pop();
    chk("partial_occ5", 32'(fifo_empty_partial), 32'd0);
    fifo_pop();
    chk("partial_occ4", 32'(fifo_empty_partial), 32'd1);
    chk("partial_head", 32'(fifo_out), 32'd102);
    fifo_rst = 1'b1;
    tick();
    fifo_rst = 1'b0;
    chk("fifo_rst_empty", 32'(fifo_empty), 32'd1);

    // 3: retry on write side (held 2 cycles), then on read side
    fifo_write(16'hAAAA);
    fifo_write(16'hBBBB);
    fifo_old_add_flag = 1'b1; fifo_wr_rd = 1'b1; fifo_enable = 1'b1; fifo_in = 16'h9999;
    tick();
    tick();
    fifo_old_add_flag = 1'b0; fifo_enable = 1'b0;
    fifo_write(16'hCCCC);
    chk("retry_head_a", 32'(fifo_out), 32'hAAAA);
    fifo_pop();
    chk("retry_head_c", 32'(fifo_out), 32'hCCCC);
    fifo_old_add_flag = 1'b1; fifo_wr_rd = 1'b0;
    tick();
    fifo_old_add_flag = 1'b0;
    chk("retry_rd_restore", 32'(fifo_out), 32'hAAAA);
    fifo_pop();
    chk("retry_then_c", 32'(fifo_out), 32'hCCCC);
    fifo_pop();
    chk("retry_final_empty", 32'(fifo_empty), 32'd1);

    // 4: counter count, load, terminal, wrap, load without enable
    cnt_en = 1'b1;
    tick(); tick(); tick();
    chk("cnt_3", 32'(cnt), 32'd3);
    cnt_load = 1'b1; cnt_data_in = 15'h7FFE;
    tick();
    cnt_load = 1'b0;
    chk("cnt_load", 32'(cnt), 32'h7FFE);
    chk("cnt_end_7ffe", 32'(cnt_end), 32'd0);
    tick();
    chk("cnt_7fff", 32'(cnt), 32'h7FFF);
    chk("cnt_end_7fff", 32'(cnt_end), 32'd1);
    tick();
    chk("cnt_wrap", 32'(cnt), 32'd0);
    chk("cnt_end_wrap", 32'(cnt_end), 32'd0);
    cnt_en = 1'b0; cnt_load = 1'b1; cnt_data_in = 15'h1234;
    tick();
    cnt_load = 1'b0;
    chk("cnt_load_no_en", 32'(cnt), 32'd0);

    // 5: register capture, hold, reset priority
    reg_en = 1'b1; reg_data_in = 16'hBEEF;
    tick();
    reg_en = 1'b0; reg_data_in = 16'h1111;
    chk("reg_beef", 32'(reg_data_out), 32'hBEEF);
    tick();
    chk("reg_hold", 32'(reg_data_out), 32'hBEEF);
    reg_en = 1'b1; reg_rst = 1'b1;
    tick();
    reg_en = 1'b0; reg_rst = 1'b0;
    chk("reg_rst_prio", 32'(reg_data_out), 32'd0);

    // 6: concurrent activity, then asynchronous reset mid-cycle
    cnt_rst = 1'b1;
    tick();
    cnt_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cnt_en      = (i < 5);
      reg_en      = (i == 0);
      reg_data_in = 16'h55AA;
      fifo_write(16'(200 + i));
    end
    cnt_en = 1'b0; reg_en = 1'b0;
    chk("mid_cnt", 32'(cnt), 32'd5);
    chk("mid_reg", 32'(reg_data_out), 32'h55AA);
    chk("mid_head", 32'(fifo_out), 32'd200);
    chk("mid_partial", 32'(fifo_empty_partial), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    #10;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
